// File: rtl/ifetch.sv
// Instruction fetch stage: issues one-at-a-time word fetches at the current PC and buffers
// {pc, inst} pairs in a small prefetch FIFO for decode; a branch flushes buffer and in-flight data.
module ifetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_pc,
    input  logic        i_branch,
    output logic        o_pc_step,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr_inc;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   pend_addr;
    logic          room;
    logic          req;
    logic          push;
    logic          pop;

    assign room         = (count < CW'(DEPTH));
    assign o_inst_valid = (count != '0);
    assign pop          = o_inst_valid && i_inst_ready;
    assign rptr_inc     = rptr + PW'(1);
    assign o_imem_req   = req;
    assign o_imem_addr  = i_pc;
    assign o_pc_step    = (req && i_imem_gnt) || i_branch;

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        push      = 1'b0;
        case (state)
            FETCH: begin
                req = !i_branch && room;
                if (req && i_imem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (i_imem_rvalid) begin
                    push      = !i_branch;
                    state_nxt = FETCH;
                end else if (i_branch) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                // the response of the flushed fetch is still owed; swallow it before refetching
                if (i_imem_rvalid) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pend_addr <= '0;
        end else begin
            state <= state_nxt;
            if (req && i_imem_gnt) pend_addr <= i_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            rptr      <= '0;
            wptr      <= '0;
            o_inst    <= '0;
            o_inst_pc <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else if (i_branch) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else begin
            if (push) begin
                mem_pc[wptr]   <= pend_addr;
                mem_inst[wptr] <= i_imem_rdata;
                wptr           <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr_inc;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // head registers track the entry that will sit at rptr next cycle, held when empty
            if (pop) begin
                if (count == CW'(1)) begin
                    if (push) begin
                        o_inst    <= i_imem_rdata;
                        o_inst_pc <= pend_addr;
                    end
                end else begin
                    o_inst    <= mem_inst[rptr_inc];
                    o_inst_pc <= mem_pc[rptr_inc];
                end
            end else if (count == '0 && push) begin
                o_inst    <= i_imem_rdata;
                o_inst_pc <= pend_addr;
            end
        end
    end

endmodule
